mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit; the sequential counterpart of the single-cycle integer ALU in the EX stage.
- Accepts MIPS mult/multu/div/divu/mthi/mtlo, computes over a fixed latency, and holds the HI/LO architectural registers.
- Pipeline control stalls mfhi/mflo and new MDU ops while busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration for multiply ops (>=1).
- DIV_CYCLES, 10, busy duration for divide ops (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MDUop  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111-1010 see Optional Feature, others none.
- start  input  1  one-cycle strobe qualifying MDUop.
- SrcA  input  32  rs operand.
- SrcB  input  32  rt operand.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, counter=0, latched operands/op cleared. Reset mid-operation aborts; no HI/LO write.
- Accept: start=1 and busy=0 at edge k with a mult/div-class op:
  - latch operands and op;
  - load counter with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0). It is high for exactly N cycles after edge k, and low again from edge k+N.
- Counter decrements each edge while nonzero. At the edge where it goes 1->0, HI/LO are written with the result.
- HI/LO hold their old values for the whole busy window.
- start while busy=1: ignored entirely, including mthi/mtlo. The pipeline must not issue while busy.
- mthi/mtlo with start=1, busy=0: HI (or LO) <= SrcA at that edge. busy stays 0 (zero latency). The other register is unchanged.
- start=1 with op none or undefined: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64. {HI,LO} = product.
  - multu: same, unsigned.
  - div: signed. LO = quotient truncated toward zero. HI = remainder, carrying the sign of the dividend (SrcA).
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Divide by zero (SrcB=0, div or divu): full DIV_CYCLES busy window runs, then HI/LO are left unchanged.
- Result may be computed combinationally from latched operands or iteratively. Only the latency and final values are architectural.
- Back-to-back: start may be accepted in the same cycle busy falls, i.e. the first cycle busy=0 after completion.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 0111 madd, 1000 maddu, 1001 msub, 1010 msubu are enabled.
  - Latency is MULT_CYCLES.
  - {HI,LO} <= {HI,LO} +/- product (signed or unsigned as named), 64-bit wrap-around.
  - The {HI,LO} value used is the one at completion, which equals the value at accept since HI/LO are frozen while busy.
- Undefined: codes 0111-1010 behave as none (no busy, no write).

Test Plan:
- Reset then idle -> HI=0, LO=0, busy=0. Reset asserted 2 cycles into a div -> busy=0 next cycle; HI/LO=0.
- mult SrcA=0xFFFFFFFF, SrcB=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div SrcA=-7 (0xFFFFFFF9), SrcB=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles -> HI/LO updated at each edge, busy never asserted. divu by 0 afterwards -> values unchanged after 10 busy cycles.
- During mult busy:
  - start with mtlo 0xDEAD -> ignored; LO equals the product at completion.
  - New mult issued the cycle busy drops -> accepted, busy re-asserts.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1x1 -> HI=1, LO=0. Without the macro, same stimulus -> no busy, HI=0, LO=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO registers.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUop,
   input  logic        start,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] r_cnt;
   logic [3:0]    r_op;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_mul_class;
   logic          w_div_class;
   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [63:0]   w_acc;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic [31:0]   w_b_mag_safe;
   logic [31:0]   w_b_safe;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_q_s;
   logic [31:0]   w_r_s;
   logic [31:0]   w_q_u;
   logic [31:0]   w_r_u;
   logic          w_wr;
   logic [63:0]   w_res;

   assign busy = (r_cnt != '0);
   assign HI   = r_hi;
   assign LO   = r_lo;

   assign w_mul_class = (MDUop == OP_MULT) || (MDUop == OP_MULTU) ||
                        (MADD_EN && (MDUop >= OP_MADD) && (MDUop <= OP_MSUBU));
   assign w_div_class = (MDUop == OP_DIV) || (MDUop == OP_DIVU);

   // Low 64 bits of the product of sign-extended operands is the signed product.
   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};
   assign w_acc    = {r_hi, r_lo};

   // Signed divide on magnitudes; the most-negative dividend has magnitude 2^31,
   // which still fits as unsigned, so 0x80000000 / -1 yields 0x80000000 naturally.
   assign w_a_mag      = r_a[31] ? -r_a : r_a;
   assign w_b_mag      = r_b[31] ? -r_b : r_b;
   assign w_b_mag_safe = (w_b_mag == '0) ? 32'd1 : w_b_mag;
   assign w_b_safe     = (r_b == '0) ? 32'd1 : r_b;
   assign w_q_mag      = w_a_mag / w_b_mag_safe;
   assign w_r_mag      = w_a_mag % w_b_mag_safe;
   assign w_q_s        = (r_a[31] ^ r_b[31]) ? -w_q_mag : w_q_mag;
   assign w_r_s        = r_a[31] ? -w_r_mag : w_r_mag;
   assign w_q_u        = r_a / w_b_safe;
   assign w_r_u        = r_a % w_b_safe;

   always_comb begin
      w_wr  = 1'b0;
      w_res = w_acc;
      case (r_op)
         OP_MULT:  begin w_wr = 1'b1; w_res = w_prod_s; end
         OP_MULTU: begin w_wr = 1'b1; w_res = w_prod_u; end
         OP_DIV:   if (r_b != '0) begin w_wr = 1'b1; w_res = {w_r_s, w_q_s}; end
         OP_DIVU:  if (r_b != '0) begin w_wr = 1'b1; w_res = {w_r_u, w_q_u}; end
         OP_MADD:  begin w_wr = 1'b1; w_res = w_acc + w_prod_s; end
         OP_MADDU: begin w_wr = 1'b1; w_res = w_acc + w_prod_u; end
         OP_MSUB:  begin w_wr = 1'b1; w_res = w_acc - w_prod_s; end
         OP_MSUBU: begin w_wr = 1'b1; w_res = w_acc - w_prod_u; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
         if ((r_cnt == CW'(1)) && w_wr) begin
            r_hi <= w_res[63:32];
            r_lo <= w_res[31:0];
         end
      end else if (start) begin
         if (w_mul_class || w_div_class) begin
            r_op  <= MDUop;
            r_a   <= SrcA;
            r_b   <= SrcB;
            r_cnt <= w_mul_class ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
         end else if (MDUop == OP_MTHI) begin
            r_hi <= SrcA;
         end else if (MDUop == OP_MTLO) begin
            r_lo <= SrcA;
         end
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops against a behavioural model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MDUop;
   logic        start;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int vectors = 0;
   int miscompares = 0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUop(MDUop), .start(start),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Behavioural model: remaining busy cycles plus the result to commit at the end.
   int          m_left = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] m_phi = '0;
   logic [31:0] m_plo = '0;
   bit          m_pwr = 1'b0;
   bit          m_valid = 1'b0;

   task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, acc, res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      acc = {m_hi, m_lo};
      res = acc;
      m_pwr = 1'b1;
      case (op)
         4'd1: begin m_left = 5; res = longint'(sa * sb); end
         4'd2: begin m_left = 5; res = ua * ub; end
         4'd3: begin
            m_left = 10;
            if (b == 0) m_pwr = 1'b0;
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         4'd4: begin
            m_left = 10;
            if (b == 0) m_pwr = 1'b0;
            else res = {32'(ua % ub), 32'(ua / ub)};
         end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
`ifdef MDU_MADD_EN
         4'd7:  begin m_left = 5; res = acc + longint'(sa * sb); end
         4'd8:  begin m_left = 5; res = acc + ua * ub; end
         4'd9:  begin m_left = 5; res = acc - longint'(sa * sb); end
         4'd10: begin m_left = 5; res = acc - ua * ub; end
`endif
         default: ;
      endcase
      m_phi = res[63:32];
      m_plo = res[31:0];
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_left = 0; m_hi = '0; m_lo = '0; m_pwr = 1'b0; m_valid = 1'b1;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (start) begin
         model_accept(MDUop, SrcA, SrcB);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         vectors++;
         if (busy !== (m_left != 0) || HI !== m_hi || LO !== m_lo) begin
            miscompares++;
            $display("FAIL model t=%0t: busy/HI/LO got %b %h %h expected %b %h %h",
                     $time, busy, HI, LO, (m_left != 0), m_hi, m_lo);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is aligned to a negedge; the op is sampled at the next posedge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      MDUop = op; SrcA = a; SrcB = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; MDUop = 4'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("busy_timeout", 32'(busy), 32'd0);
   endtask

   int n;
   logic [3:0]  r_op;
   logic [31:0] r_a, r_b;

   initial begin
      reset = 1'b1; start = 1'b0; MDUop = '0; SrcA = '0; SrcB = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hi", HI, 32'h0);
      chk("reset_lo", LO, 32'h0);

      issue(4'd1, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      chk("mult_busy_len", n, 32'd5);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFFE);

      issue(4'd2, 32'hFFFFFFFF, 32'd2);
      wait_idle(n);
      chk("multu_hi", HI, 32'h00000001);
      chk("multu_lo", LO, 32'hFFFFFFFE);

      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      chk("div_busy_len", n, 32'd10);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);

      issue(4'd4, 32'd7, 32'd2);
      wait_idle(n);
      chk("divu_lo", LO, 32'd3);
      chk("divu_hi", HI, 32'd1);

      issue(4'd5, 32'h12345678, 32'd0);
      chk("mthi_busy", 32'(busy), 32'd0);
      chk("mthi_hi", HI, 32'h12345678);
      issue(4'd6, 32'h9ABCDEF0, 32'd0);
      chk("mtlo_busy", 32'(busy), 32'd0);
      chk("mtlo_lo", LO, 32'h9ABCDEF0);
      chk("mtlo_hi_kept", HI, 32'h12345678);

      issue(4'd4, 32'd99, 32'd0);
      wait_idle(n);
      chk("div0_busy_len", n, 32'd10);
      chk("div0_hi", HI, 32'h12345678);
      chk("div0_lo", LO, 32'h9ABCDEF0);

      issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      chk("divovf_lo", LO, 32'h80000000);
      chk("divovf_hi", HI, 32'h0);

      issue(4'd1, 32'd3, 32'd5);
      issue(4'd6, 32'h0000DEAD, 32'd0);
      wait_idle(n);
      chk("mtlo_ignored_lo", LO, 32'd15);
      chk("mtlo_ignored_hi", HI, 32'd0);
      issue(4'd1, 32'd7, 32'd7);
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_idle(n);
      chk("b2b_busy_len", n, 32'd5);
      chk("b2b_lo", LO, 32'd49);

      issue(4'd3, 32'd100, 32'd3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", HI, 32'h0);
      chk("abort_lo", LO, 32'h0);

      issue(4'd5, 32'h0, 32'd0);
      issue(4'd6, 32'hFFFFFFFF, 32'd0);
      issue(4'd8, 32'd1, 32'd1);
      wait_idle(n);
`ifdef MDU_MADD_EN
      chk("maddu_busy_len", n, 32'd5);
      chk("maddu_hi", HI, 32'h1);
      chk("maddu_lo", LO, 32'h0);
`else
      chk("maddu_busy_len", n, 32'd0);
      chk("maddu_hi", HI, 32'h0);
      chk("maddu_lo", LO, 32'hFFFFFFFF);
`endif

      for (int i = 0; i < 600; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = $urandom;
         r_b  = $urandom;
         case ($urandom_range(0, 9))
            0: r_b = 32'h0;
            1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
            2: r_b = 32'($urandom_range(1, 9));
            3: r_b = -32'($urandom_range(1, 9));
            default: ;
         endcase
         MDUop = r_op; SrcA = r_a; SrcB = r_b;
         start = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      start = 1'b0; MDUop = 4'd0;
      wait_idle(n);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
